jtkicker_romrq: RTL and testbench



---
 rtl/jtkicker_romrq.sv | 117 +++++++++++
 tb/tb_jtkicker_romrq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkicker_romrq.sv
// Main-CPU ROM read responder: byte reads -> 16-bit SDRAM word fetches, tag-store hits answered combinationally.
// Define JTKICKER_ROMRQ_2WAY_EN for a two-entry LRU store; default is a single entry.
module jtkicker_romrq #(
  parameter int          AW     = 16,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [7:0]    rom_data,
  output logic          rom_ok,
  output logic          sdram_req,
  output logic [21:0]   sdram_addr,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  input  logic [15:0]   sdram_din
);

  localparam int TW = AW - 1;
`ifdef JTKICKER_ROMRQ_2WAY_EN
  localparam int NW = 2;
`else
  localparam int NW = 1;
`endif

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   rom_tag, tag_pend;
  logic [21:0]     word_addr;
  logic [NW-1:0]   valid, hit_vec, victim;
  logic [TW-1:0]   tags  [NW];
  logic [15:0]     words [NW];
  logic [15:0]     hit_word;
  logic            hit, fill;

  assign rom_tag   = rom_addr[AW-1:1];
  assign word_addr = OFFSET + 22'(rom_tag);

  always_comb begin
    hit_vec  = '0;
    hit_word = words[0];
    for (int i = 0; i < NW; i++) begin
      hit_vec[i] = valid[i] && (tags[i] == rom_tag);
      if (hit_vec[i]) hit_word = words[i];
    end
  end

  assign hit      = rom_cs && (|hit_vec);
  assign rom_ok   = hit;
  assign rom_data = rom_addr[0] ? hit_word[15:8] : hit_word[7:0];

`ifdef JTKICKER_ROMRQ_2WAY_EN
  logic lru;  // index of the least-recently-used way

  // A same-cycle hit protects the way it touched from being the fill victim.
  always_comb begin
    if (hit) victim = hit_vec[0] ? 2'b10 : 2'b01;
    else     victim = lru ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst)       lru <= 1'b0;
    else if (fill) lru <= victim[0];
    else if (hit)  lru <= hit_vec[0];
  end
`else
  assign victim = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rom_cs && !hit) state_nx = REQ;
      REQ:     if (sdram_ack) state_nx = sdram_rdy ? IDLE : WAIT;
      WAIT:    if (sdram_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sdram_req = (state == REQ);
    fill      = ((state == REQ) && sdram_ack && sdram_rdy) ||
                ((state == WAIT) && sdram_rdy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sdram_addr <= '0;
      tag_pend   <= '0;
      valid      <= '0;
      for (int i = 0; i < NW; i++) begin
        tags[i]  <= '0;
        words[i] <= '0;
      end
    end else begin
      if (state == IDLE && rom_cs && !hit) begin
        sdram_addr <= word_addr;
        tag_pend   <= rom_tag;
      end
      for (int i = 0; i < NW; i++) begin
        if (fill && victim[i]) begin
          valid[i] <= 1'b1;
          tags[i]  <= tag_pend;
          words[i] <= sdram_din;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtkicker_romrq.sv
// Directed bench for jtkicker_romrq with a recency-queue reference model checked every cycle.
// Expectations follow JTKICKER_ROMRQ_2WAY_EN when it is defined.
module tb_jtkicker_romrq;

  localparam int          AW     = 16;
  localparam logic [21:0] OFFSET = 22'h3FFFF8;
`ifdef JTKICKER_ROMRQ_2WAY_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 0;
  logic          rst = 1;
  logic          rom_cs = 0;
  logic [AW-1:0] rom_addr = '0;
  logic [7:0]    rom_data;
  logic          rom_ok;
  logic          sdram_req;
  logic [21:0]   sdram_addr;
  logic          sdram_ack = 0;
  logic          sdram_rdy = 0;
  logic [15:0]   sdram_din = '0;

  jtkicker_romrq #(.AW(AW), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .sdram_req(sdram_req),
    .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy),
    .sdram_din(sdram_din)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  // Reference model: entries held in recency order, least recent first.
  typedef struct { int tag; logic [15:0] word; } ent_t;
  ent_t        mq[$];
  bit          mbusy = 0, mreq = 0, mfill;
  logic [21:0] maddr = '0;
  int          mpend, mw, midx;
  ent_t        mtmp;

  function automatic int find(input int tag);
    foreach (mq[i]) if (mq[i].tag == tag) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mbusy = 0; mreq = 0; maddr = '0;
    end else begin
      mw    = int'(rom_addr) / 2;
      midx  = find(mw);
      mfill = 0;
      if (rom_cs && midx >= 0) begin
        mtmp = mq[midx];
        mq.delete(midx);
        mq.push_back(mtmp);
      end
      if (!mbusy) begin
        if (rom_cs && midx < 0) begin
          mbusy = 1; mreq = 1; mpend = mw;
          maddr = 22'((int'(OFFSET) + mw) % (1 << 22));
        end
      end else if (mreq) begin
        if (sdram_ack) begin
          mreq = 0;
          if (sdram_rdy) mfill = 1;
        end
      end else if (sdram_rdy) mfill = 1;
      if (mfill) begin
        if (mq.size() == CAP) void'(mq.pop_front());
        mtmp.tag  = mpend;
        mtmp.word = sdram_din;
        mq.push_back(mtmp);
        mbusy = 0;
      end
    end
  end

  int          cidx;
  logic [7:0]  cbyte;
  always @(negedge clk) begin
    if (started) begin
      chk("model_req", 32'(sdram_req), 32'(mreq));
      chk("model_addr", 32'(sdram_addr), 32'(maddr));
      cidx = rom_cs ? find(int'(rom_addr) / 2) : -1;
      chk("model_ok", 32'(rom_ok), 32'(cidx >= 0));
      if (cidx >= 0) begin
        cbyte = rom_addr[0] ? mq[cidx].word[15:8] : mq[cidx].word[7:0];
        chk("model_data", 32'(rom_data), 32'(cbyte));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input int na, input int nr, input bit same, input logic [15:0] din);
    int t = 0;
    while (!sdram_req && t < 20) begin
      cyc();
      t++;
    end
    chk("req_seen", 32'(sdram_req), 32'd1);
    repeat (na) cyc();
    sdram_ack = 1;
    if (same) begin
      sdram_rdy = 1;
      sdram_din = din;
    end
    cyc();
    sdram_ack = 0;
    sdram_rdy = 0;
    if (!same) begin
      repeat (nr) cyc();
      sdram_rdy = 1;
      sdram_din = din;
      cyc();
      sdram_rdy = 0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    started = 1;
    cyc();
    chk("rst_req", 32'(sdram_req), 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_ok", 32'(rom_ok), 32'd0);
    rst = 0;

    // first miss, slow handshake
    rom_cs = 1; rom_addr = 16'h0000;
    #1 chk("miss_ok", 32'(rom_ok), 32'd0);
    cyc();
    chk("first_req", 32'(sdram_req), 32'd1);
    chk("first_addr", 32'(sdram_addr), 32'h3FFFF8);
    serve(1, 2, 0, 16'hA55A);
    chk("fill_ok", 32'(rom_ok), 32'd1);
    chk("fill_lo", 32'(rom_data), 32'h5A);
    rom_addr = 16'h0001;
    #1;
    chk("odd_ok", 32'(rom_ok), 32'd1);
    chk("odd_hi", 32'(rom_data), 32'hA5);
    cyc();
    chk("odd_noreq", 32'(sdram_req), 32'd0);

    // wrapping address, CPU address moves during WAIT
    rom_addr = 16'h0010;
    cyc();
    chk("wrap_addr", 32'(sdram_addr), 32'h000000);
    cyc();
    sdram_ack = 1;
    cyc();
    sdram_ack = 0;
    rom_addr = 16'h0020;
    cyc();
    chk("wait_noreq", 32'(sdram_req), 32'd0);
    chk("addr_stable", 32'(sdram_addr), 32'h000000);
    sdram_rdy = 1; sdram_din = 16'h1234;
    cyc();
    sdram_rdy = 0;
    chk("idle_noreq", 32'(sdram_req), 32'd0);
    cyc();
    chk("next_req", 32'(sdram_req), 32'd1);
    chk("next_addr", 32'(sdram_addr), 32'h000008);
    serve(0, 0, 0, 16'hBEEF);
    chk("beef_hi", 32'(rom_addr[0] ? rom_data : 8'h00), 32'h00);
    rom_addr = 16'h0021;
    #1 chk("beef_data", 32'(rom_data), 32'hBE);

    // reset while in WAIT, late rdy ignored
    rom_addr = 16'h0030;
    cyc();
    sdram_ack = 1;
    cyc();
    sdram_ack = 0;
    rst = 1; rom_cs = 0;
    cyc();
    rst = 0; sdram_rdy = 1; sdram_din = 16'hDEAD;
    cyc();
    sdram_rdy = 0;
    chk("rst_wait_req", 32'(sdram_req), 32'd0);
    rom_cs = 1;
    #1 chk("no_fill", 32'(rom_ok), 32'd0);
    rom_addr = 16'h0020;
    #1 chk("cleared", 32'(rom_ok), 32'd0);

    // same-cycle ack+rdy
    rom_addr = 16'h0030;
    cyc();
    serve(0, 0, 1, 16'hC3C3);
    chk("same_ok", 32'(rom_ok), 32'd1);
    chk("same_data", 32'(rom_data), 32'hC3);

    // replacement: A, B, A, C, B
    rst = 1;
    cyc();
    rst = 0;
    rom_addr = 16'h0100; cyc(); serve(0, 1, 0, 16'h1111);
    rom_addr = 16'h0200; cyc(); serve(1, 0, 0, 16'h2222);
    rom_addr = 16'h0100;
    #1;
`ifdef JTKICKER_ROMRQ_2WAY_EN
    chk("a_rehit", 32'(rom_ok), 32'd1);
    chk("a_data", 32'(rom_data), 32'h11);
    cyc();
    chk("a_noreq", 32'(sdram_req), 32'd0);
`else
    chk("a_remiss", 32'(rom_ok), 32'd0);
    cyc();
    chk("a_req", 32'(sdram_req), 32'd1);
    serve(0, 0, 0, 16'h1111);
`endif
    rom_addr = 16'h0300; cyc(); serve(0, 0, 0, 16'h3333);
    rom_addr = 16'h0201;
    #1 chk("b_evicted", 32'(rom_ok), 32'd0);
    cyc();
    chk("b_req", 32'(sdram_req), 32'd1);
    serve(0, 0, 0, 16'h2222);
    chk("b_data", 32'(rom_data), 32'h22);
    rom_addr = 16'h0300;
    #1;
`ifdef JTKICKER_ROMRQ_2WAY_EN
    chk("c_kept", 32'(rom_ok), 32'd1);
`else
    chk("c_gone", 32'(rom_ok), 32'd0);
`endif
    rom_cs = 0;
    cyc();
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
